store_align_unit: RTL and testbench
===================================

Name: store_align_unit

Overview:
Store-path counterpart to the load-path sign/zero extenders in the memory stage. It accepts a byte, half-word or word store from the execute/memory stage and places the data on the correct byte lanes of a word-wide data memory with byte enables. A store that crosses a word boundary is split into two word-aligned write beats.
- Valid/ready handshake on the request side; write/ready handshake on the memory side.

Parameters:
WORD_LENGTH, 32, data word width (fixed at 32; 4 byte lanes)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  store request present
req_ready  out  1  unit can accept a request (IDLE only)
req_addr  in  ADDR_WIDTH  byte address of store
req_data  in  WORD_LENGTH  store data, right-justified; bits above size ignored
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
mem_we  out  1  write beat valid
mem_ready  in  1  memory accepts the beat this cycle
mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0]=00
mem_wdata  out  WORD_LENGTH  lane-aligned data; disabled lanes driven 0
mem_be  out  4  byte enables, bit i = lane i (bits 8i+7:8i)
done  out  1  one-cycle pulse after the final beat is accepted or an illegal request is dropped
err  out  1  one-cycle pulse with done, for an illegal size only

Behaviour:
- Reset (async on rst_n low): state=IDLE, req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0.
- Reset asserted mid-operation discards pending beats; no partial completion is reported.
- Handshake rules:
  - A request is accepted when req_valid && req_ready. On acceptance, addr, data (masked to size) and size are registered.
  - A beat is accepted when mem_we && mem_ready.
  - mem_* outputs stay stable while mem_we=1 and mem_ready=0.
- No combinational path from req_* or mem_ready to any output. All outputs derive from registers or the state; done and err are registered.
- States:
  - IDLE: req_ready=1, mem_we=0.
    - Accept of legal size goes to BEAT0.
    - Accept of size 11 stays in IDLE, pulses done=1/err=1 the next cycle, and issues no write.
  - BEAT0: mem_we=1, mem_addr={addr[AW-1:2],00}.
    - nbytes = 1/2/4 and off = addr[1:0].
    - mem_be = low 4 bits of (mask(nbytes) << off).
    - mem_wdata = low 32 bits of (data << 8*off).
    - On beat accept: if off+nbytes > 4, go to BEAT1; else go to IDLE and pulse done next cycle.
  - BEAT1: mem_we=1, mem_addr = word addr + 4 (wraps modulo 2^ADDR_WIDTH).
    - mem_be = mask(nbytes) >> (4-off).
    - mem_wdata = data >> 8*(4-off).
    - On beat accept, go to IDLE and pulse done next cycle.
- Latency with mem_ready=1:
  - Aligned store accepted at cycle N: beat at N+1, done at N+2.
  - Split store: beats at N+1 and N+2, done at N+3.
- Throughput: req_ready returns high in the same cycle done pulses, so a new request is accepted that cycle.
- Byte stores never split. Half-word splits only when off=3. Word splits for any off≠0.

Decomposition:
- Package store_pkg:
  - enum store_size_t (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11)
  - enum store_state_t (IDLE, BEAT0, BEAT1)
  - localparam NUM_LANES=4
- Sub-module store_lane_align: purely combinational. Inputs are off, size, data and a beat select. Outputs are be, wdata and a split flag. The FSM top instantiates it once.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, mem_ready=1 -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF; done 2 cycles after accept.
- SB addr 0x103 data 0xFFFFFFA5 -> one beat: addr 0x100, be 1000, wdata 0xA5000000.
- SH addr 0x103 data 0x00001234 -> two beats:
  - beat 0: addr 0x100, be 1000, wdata 0x34000000
  - beat 1: addr 0x104, be 0001, wdata 0x00000012
- SW addr 0x102 data 0xAABBCCDD with mem_ready low for 3 cycles on beat 0:
  - beat 0 held stable: addr 0x100, be 1100, wdata 0xCCDD0000
  - beat 1: addr 0x104, be 0011, wdata 0x0000AABB
- SW addr 0xFFFFFFFE data 0x11223344 -> beat 1 addr wraps to 0x00000000, be 0011, wdata 0x00001122.
- size=11 -> no mem_we, done=1/err=1 next cycle. Then rst_n pulsed low during BEAT1 of a split store -> all outputs 0 immediately, no done; next request proceeds normally.

Source files
------------

// File: rtl/store_pkg.sv
// ---------------------------------------------------------------------------
// store_pkg
// Shared types for the store alignment path: store size encoding, the beat
// sequencer states, the lane count and a helper that maps a store size to
// its right-justified byte-lane mask.
// ---------------------------------------------------------------------------
package store_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } store_size_t;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } store_state_t;

    // Right-justified lane mask for a store of the given size (lane 0 = LSB).
    function automatic logic [NUM_LANES-1:0] size_lane_mask(input store_size_t size);
        case (size)
            SZ_BYTE: size_lane_mask = 4'b0001;
            SZ_HALF: size_lane_mask = 4'b0011;
            SZ_WORD: size_lane_mask = 4'b1111;
            default: size_lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// ---------------------------------------------------------------------------
// store_lane_align
// Purely combinational lane placement for one write beat of a store.
//   off      : byte offset of the store within its word (addr[1:0])
//   size     : store size
//   data     : right-justified store data, already masked to size
//   beat_sel : 0 = first (lower-word) beat, 1 = second (next-word) beat
//   be       : byte enables for the selected beat
//   wdata    : lane-aligned data for the selected beat, unused lanes zero
//   split    : store spans two words and needs a second beat
// ---------------------------------------------------------------------------
module store_lane_align
    import store_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [1:0]             off,
    input  store_size_t            size,
    input  logic [WORD_LENGTH-1:0] data,
    input  logic                   beat_sel,
    output logic [NUM_LANES-1:0]   be,
    output logic [WORD_LENGTH-1:0] wdata,
    output logic                   split
);

    logic [NUM_LANES-1:0] mask;
    logic [2:0]           nbytes;

    always_comb begin
        mask   = size_lane_mask(size);
        nbytes = 3'd0;
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            SZ_WORD: nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase

        // off + nbytes tops out at 7, so 3 bits hold the sum without overflow.
        split = (({1'b0, off} + nbytes) > 3'd4);

        if (!beat_sel) begin
            // Lanes shifted past lane 3 fall off here and reappear in beat 1.
            be    = mask << off;
            wdata = data << {off, 3'b000};
        end else begin
            // Bring down exactly the lanes that overflowed the first word.
            be    = mask >> (3'd4 - {1'b0, off});
            wdata = data >> (6'd32 - {1'b0, off, 3'b000});
        end
    end

endmodule

// File: rtl/store_align_unit.sv
// ---------------------------------------------------------------------------
// store_align_unit
// Places byte/half/word stores onto the byte lanes of a word-wide data
// memory, splitting word-crossing stores into two aligned write beats.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : store request handshake (ready only while idle)
//   req_addr/data/size: byte address, right-justified data, size code
//   mem_we/ready      : write beat handshake towards memory
//   mem_addr          : word-aligned beat address
//   mem_wdata/mem_be  : lane-aligned data and byte enables
//   done              : one-cycle pulse when a store completes or is dropped
//   err               : pulses with done when the dropped store had size 11
// ---------------------------------------------------------------------------
module store_align_unit
    import store_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [WORD_LENGTH-1:0] req_data,
    input  logic [1:0]             req_size,
    output logic                   mem_we,
    input  logic                   mem_ready,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    output logic [NUM_LANES-1:0]   mem_be,
    output logic                   done,
    output logic                   err
);

    store_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_LENGTH-1:0]  data_q, data_d;
    store_size_t             size_q, size_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    store_size_t             req_size_t;
    logic [NUM_LANES-1:0]    req_mask;
    logic [WORD_LENGTH-1:0]  req_data_masked;

    logic [NUM_LANES-1:0]    align_be;
    logic [WORD_LENGTH-1:0]  align_wdata;
    logic                    align_split;
    logic [ADDR_WIDTH-1:0]   word_addr;

    // Lane placement always works from the registered request, so no
    // request-side input ever reaches the memory outputs combinationally.
    store_lane_align #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_lane_align (
        .off      (addr_q[1:0]),
        .size     (size_q),
        .data     (data_q),
        .beat_sel (state_q == BEAT1),
        .be       (align_be),
        .wdata    (align_wdata),
        .split    (align_split)
    );

    // Drop the bytes above the store size before they are registered.
    always_comb begin
        req_size_t      = store_size_t'(req_size);
        req_mask        = size_lane_mask(req_size_t);
        req_data_masked = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            req_data_masked[8*i +: 8] = req_mask[i] ? req_data[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_size_t == SZ_ILL) begin
                        // Illegal size: report and drop without any write.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        data_d  = req_data_masked;
                        size_d  = req_size_t;
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (align_split) begin
                        state_d = BEAT1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SZ_BYTE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from state and registered request only; memory
    // signals are forced to zero outside a beat so reset/idle read as 0.
    always_comb begin
        word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        req_ready = (state_q == IDLE);
        mem_we    = (state_q == BEAT0) || (state_q == BEAT1);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state_q == BEAT0) begin
            mem_addr  = word_addr;
            mem_wdata = align_wdata;
            mem_be    = align_be;
        end else if (state_q == BEAT1) begin
            // Next word; wraps naturally at the top of the address space.
            mem_addr  = word_addr + {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
            mem_wdata = align_wdata;
            mem_be    = align_be;
        end
        done = done_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_store_align_unit.sv
// ---------------------------------------------------------------------------
// tb_store_align_unit
// Directed bench for store_align_unit with hand-computed beat expectations.
// ---------------------------------------------------------------------------
module tb_store_align_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    int n_tests;
    int n_fail;

    store_align_unit #(
        .WORD_LENGTH (32),
        .ADDR_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request just after a rising edge; it is accepted on the next edge.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        @(negedge clk);
        check({tag, ".we"},    {31'd0, mem_we},    32'd1);
        check({tag, ".addr"},  mem_addr,           addr);
        check({tag, ".be"},    {28'd0, mem_be},    {28'd0, be});
        check({tag, ".wdata"}, mem_wdata,          wdata);
        check({tag, ".done"},  {31'd0, done},      32'd0);
        check({tag, ".rdy"},   {31'd0, req_ready}, 32'd0);
    endtask

    task automatic chk_done(input string tag, input logic exp_err);
        @(negedge clk);
        check({tag, ".done"}, {31'd0, done},      32'd1);
        check({tag, ".err"},  {31'd0, err},       {31'd0, exp_err});
        check({tag, ".we"},   {31'd0, mem_we},    32'd0);
        check({tag, ".rdy"},  {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_quiet(input string tag);
        @(negedge clk);
        check({tag, ".done"}, {31'd0, done},   32'd0);
        check({tag, ".err"},  {31'd0, err},    32'd0);
        check({tag, ".we"},   {31'd0, mem_we}, 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = 2'b00;
        mem_ready = 1'b1;

        // Reset state
        #12;
        check("rst.rdy",   {31'd0, req_ready}, 32'd1);
        check("rst.we",    {31'd0, mem_we},    32'd0);
        check("rst.addr",  mem_addr,           32'd0);
        check("rst.wdata", mem_wdata,          32'd0);
        check("rst.be",    {28'd0, mem_be},    32'd0);
        check("rst.done",  {31'd0, done},      32'd0);
        check("rst.err",   {31'd0, err},       32'd0);
        #11;
        rst_n = 1'b1;

        // Aligned word store
        issue(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
        chk_beat("sw_al", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        chk_done("sw_al", 1'b0);
        chk_quiet("sw_al_after");

        // Byte store in lane 3, upper data bits must be discarded
        issue(32'h0000_0103, 32'hFFFF_FFA5, 2'b00);
        chk_beat("sb3", 32'h0000_0100, 4'b1000, 32'hA500_0000);
        chk_done("sb3", 1'b0);

        // Half-word at offset 3 splits across two words
        issue(32'h0000_0103, 32'h0000_1234, 2'b01);
        chk_beat("sh3.b0", 32'h0000_0100, 4'b1000, 32'h3400_0000);
        chk_beat("sh3.b1", 32'h0000_0104, 4'b0001, 32'h0000_0012);
        chk_done("sh3", 1'b0);

        // Half-word at offset 1 does not split; upper half must be masked
        issue(32'h0000_0201, 32'hFFFF_5678, 2'b01);
        chk_beat("sh1", 32'h0000_0200, 4'b0110, 32'h0056_7800);
        chk_done("sh1", 1'b0);

        // Split word with beat 0 stalled for three cycles
        mem_ready = 1'b0;
        issue(32'h0000_0102, 32'hAABB_CCDD, 2'b10);
        for (int i = 0; i < 3; i++) begin
            chk_beat("sw2.stall", 32'h0000_0100, 4'b1100, 32'hCCDD_0000);
        end
        chk_beat("sw2.b0", 32'h0000_0100, 4'b1100, 32'hCCDD_0000);
        mem_ready = 1'b1;
        chk_beat("sw2.b1", 32'h0000_0104, 4'b0011, 32'h0000_AABB);
        chk_done("sw2", 1'b0);

        // Split word at top of address space: beat 1 wraps to zero
        issue(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
        chk_beat("wrap.b0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
        chk_beat("wrap.b1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
        chk_done("wrap", 1'b0);

        // Back-to-back: a request offered in the done cycle is taken there
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0300;
        req_data  = 32'h0000_00C3;
        req_size  = 2'b00;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0402;
        req_data  = 32'h0000_BEEF;
        req_size  = 2'b01;
        @(negedge clk);
        check("b2b.a.be", {28'd0, mem_be}, 32'h0000_0001);
        check("b2b.a.wd", mem_wdata,        32'h0000_00C3);
        @(negedge clk);
        check("b2b.a.done", {31'd0, done},      32'd1);
        check("b2b.a.rdy",  {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk_beat("b2b.b", 32'h0000_0400, 4'b1100, 32'hBEEF_0000);
        chk_done("b2b.b", 1'b0);

        // Illegal size: no write, done+err next cycle
        issue(32'h0000_0500, 32'h1234_5678, 2'b11);
        @(negedge clk);
        check("ill.we",   {31'd0, mem_we},    32'd0);
        check("ill.done", {31'd0, done},      32'd1);
        check("ill.err",  {31'd0, err},       32'd1);
        check("ill.rdy",  {31'd0, req_ready}, 32'd1);
        chk_quiet("ill_after");

        // Reset during beat 1 of a split store
        issue(32'h0000_0101, 32'h5566_7788, 2'b10);
        chk_beat("rstmid.b0", 32'h0000_0100, 4'b1110, 32'h6677_8800);
        chk_beat("rstmid.b1", 32'h0000_0104, 4'b0001, 32'h0000_0055);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.we",    {31'd0, mem_we},    32'd0);
        check("rstmid.addr",  mem_addr,           32'd0);
        check("rstmid.wdata", mem_wdata,          32'd0);
        check("rstmid.be",    {28'd0, mem_be},    32'd0);
        check("rstmid.done",  {31'd0, done},      32'd0);
        check("rstmid.rdy",   {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk_quiet("rstmid.q0");
        chk_quiet("rstmid.q1");

        // Normal operation after reset
        issue(32'h0000_0600, 32'h0BAD_F00D, 2'b10);
        chk_beat("post", 32'h0000_0600, 4'b1111, 32'h0BAD_F00D);
        chk_done("post", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
